// File: rtl/memory_access_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
// Handshake: the master raises me_o_req with addr/we/wdata/wmask and holds all of them stable until the slave pulses me_i_ack for one cycle; read data is valid in that same ack cycle; one transaction outstanding at most.
`ifndef MEMORY_ACCESS_DEFS
`define MEMORY_ACCESS_DEFS
`define OPCODE_WIDTH 11
`define LOAD_WORD 0
`define STORE_WORD 1
`endif

interface memory_access_if #(
  parameter int DWIDTH = 32
);
  logic              me_o_req;
  logic              me_o_we;
  logic [DWIDTH-1:0] me_o_addr;
  logic [DWIDTH-1:0] me_o_wdata;
  logic [3:0]        me_o_wmask;
  logic              me_i_ack;
  logic [DWIDTH-1:0] me_i_rdata;

  modport master (
    output me_o_req, me_o_we, me_o_addr, me_o_wdata, me_o_wmask,
    input  me_i_ack, me_i_rdata
  );

  modport slave (
    input  me_o_req, me_o_we, me_o_addr, me_o_wdata, me_o_wmask,
    output me_i_ack, me_i_rdata
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage: byte/half/word loads and stores over a single-outstanding req/ack bus,
// one-cycle passthrough for non-memory instructions, combinational stall upstream.
`ifndef MEMORY_ACCESS_DEFS
`define MEMORY_ACCESS_DEFS
`define OPCODE_WIDTH 11
`define LOAD_WORD 0
`define STORE_WORD 1
`endif

module memory_access #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                     me_clk,
  input  logic                     me_rst,
  input  logic                     me_i_ce,
  input  logic                     me_i_flush,
  input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]   me_i_funct3,
  input  logic [DWIDTH-1:0]        me_i_alu_value,
  input  logic [DWIDTH-1:0]        me_i_data_rs2,
  input  logic [AWIDTH-1:0]        me_i_addr_rd,
  input  logic [DWIDTH-1:0]        me_i_data_rd,
  input  logic                     me_i_we_reg,
  memory_access_if.master          me_bus,
  output logic                     me_o_stall,
  output logic                     me_o_ce,
  output logic                     me_o_we_reg,
  output logic [AWIDTH-1:0]        me_o_addr_rd,
  output logic [DWIDTH-1:0]        me_o_data_rd,
  output logic                     me_o_misaligned,
  output logic                     me_o_dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]             r_state;
  logic                   r_req;
  logic                   r_we;
  logic [DWIDTH-1:0]      r_addr;
  logic [DWIDTH-1:0]      r_wdata;
  logic [3:0]             r_wmask;
  logic [1:0]             r_off;
  logic [FUNCT_WIDTH-1:0] r_funct3;
  logic [AWIDTH-1:0]      r_rd;
  logic                   r_is_load;
  logic                   r_ce;
  logic                   r_we_reg;
  logic [AWIDTH-1:0]      r_addr_rd;
  logic [DWIDTH-1:0]      r_data_rd;
  logic                   r_misaligned;

  logic              w_accept;
  logic              w_is_store;
  logic              w_mem;
  logic              w_byte;
  logic              w_half;
  logic              w_misaligned;
  logic [DWIDTH-1:0] w_st_data;
  logic [3:0]        w_st_mask;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [DWIDTH-1:0] w_ld_data;
  logic              w_unused;

  assign w_accept     = (r_state == IDLE) && me_i_ce && !me_i_flush;
  assign w_is_store   = me_i_opcode[`STORE_WORD];
  assign w_mem        = w_accept && (me_i_opcode[`LOAD_WORD] || w_is_store);
  // funct3[1:0] alone decides the size; bit 2 only selects zero-extension.
  assign w_byte       = (me_i_funct3[1:0] == 2'b00);
  assign w_half       = (me_i_funct3[1:0] == 2'b01);
  assign w_misaligned = w_half ? me_i_alu_value[0]
                      : (!w_byte && (me_i_alu_value[1:0] != 2'b00));
  assign w_unused     = ^{me_i_opcode, r_addr[1:0]};

  always_comb begin
    w_st_data = me_i_data_rs2;
    w_st_mask = 4'b1111;
    if (w_byte) begin
      w_st_data = {4{me_i_data_rs2[7:0]}};
      w_st_mask = 4'b0001 << me_i_alu_value[1:0];
    end else if (w_half) begin
      w_st_data = {2{me_i_data_rs2[15:0]}};
      w_st_mask = me_i_alu_value[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    w_ld_byte = me_bus.me_i_rdata[7:0];
    case (r_off)
      2'd1:    w_ld_byte = me_bus.me_i_rdata[15:8];
      2'd2:    w_ld_byte = me_bus.me_i_rdata[23:16];
      2'd3:    w_ld_byte = me_bus.me_i_rdata[31:24];
      default: w_ld_byte = me_bus.me_i_rdata[7:0];
    endcase
    w_ld_half = r_off[1] ? me_bus.me_i_rdata[31:16] : me_bus.me_i_rdata[15:0];
    case (r_funct3[2:0])
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {24'h0, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {16'h0, w_ld_half};
      default: w_ld_data = me_bus.me_i_rdata;
    endcase
  end

  always_ff @(posedge me_clk) begin
    if (!me_rst) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= 4'b0000;
      r_off        <= 2'b00;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_is_load    <= 1'b0;
      r_ce         <= 1'b0;
      r_we_reg     <= 1'b0;
      r_addr_rd    <= '0;
      r_data_rd    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_ce         <= 1'b0;
      r_we_reg     <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem && w_misaligned) begin
            r_ce         <= 1'b1;
            r_misaligned <= 1'b1;
            r_addr_rd    <= me_i_addr_rd;
          end else if (w_mem) begin
            r_state   <= BUSY;
            r_req     <= 1'b1;
            r_we      <= w_is_store;
            r_addr    <= {me_i_alu_value[DWIDTH-1:2], 2'b00};
            r_wdata   <= w_is_store ? w_st_data : '0;
            r_wmask   <= w_is_store ? w_st_mask : 4'b0000;
            r_off     <= me_i_alu_value[1:0];
            r_funct3  <= me_i_funct3;
            r_rd      <= me_i_addr_rd;
            r_is_load <= !w_is_store;
          end else if (w_accept) begin
            r_ce      <= 1'b1;
            r_we_reg  <= me_i_we_reg;
            r_addr_rd <= me_i_addr_rd;
            r_data_rd <= me_i_data_rd;
          end
        end
        BUSY: begin
          // Flush and ce are ignored here: an issued bus transaction always completes.
          if (me_bus.me_i_ack) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_ce      <= 1'b1;
            r_addr_rd <= r_rd;
            if (r_is_load) begin
              r_data_rd <= w_ld_data;
              r_we_reg  <= (r_rd != '0);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign me_o_stall = me_rst && (((r_state == IDLE) && w_mem && !w_misaligned)
                                 || ((r_state == BUSY) && !me_bus.me_i_ack));

  assign me_bus.me_o_req   = r_req;
  assign me_bus.me_o_we    = r_we;
  assign me_bus.me_o_addr  = r_addr;
  assign me_bus.me_o_wdata = r_wdata;
  assign me_bus.me_o_wmask = r_wmask;
  assign me_o_ce           = r_ce;
  assign me_o_we_reg       = r_we_reg;
  assign me_o_addr_rd      = r_addr_rd;
  assign me_o_data_rd      = r_data_rd;
  assign me_o_misaligned   = r_misaligned;
  assign me_o_dbg_state    = r_state;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: table of single instructions plus hand-written
// sequences for reset, flush passthrough, flush during BUSY and reset during BUSY.
`ifndef MEMORY_ACCESS_DEFS
`define MEMORY_ACCESS_DEFS
`define OPCODE_WIDTH 11
`define LOAD_WORD 0
`define STORE_WORD 1
`endif

module tb_memory_access;

  localparam logic [10:0] OP_LD  = 11'h001;
  localparam logic [10:0] OP_ST  = 11'h002;
  localparam logic [10:0] OP_ADD = 11'h004;

  typedef struct {
    string       name;
    logic [10:0] opcode;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic        bus;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic        e_we_reg;
    logic        e_mis;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        flush;
  logic [10:0] opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_value;
  logic [31:0] data_rs2;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        we_reg;
  logic        stall;
  logic        o_ce;
  logic        o_we_reg;
  logic [4:0]  o_addr_rd;
  logic [31:0] o_data_rd;
  logic        o_mis;
  logic        o_state;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[13];

  memory_access_if #(.DWIDTH(32)) bus ();

  memory_access dut (
    .me_clk          (clk),
    .me_rst          (rst),
    .me_i_ce         (ce),
    .me_i_flush      (flush),
    .me_i_opcode     (opcode),
    .me_i_funct3     (funct3),
    .me_i_alu_value  (alu_value),
    .me_i_data_rs2   (data_rs2),
    .me_i_addr_rd    (addr_rd),
    .me_i_data_rd    (data_rd),
    .me_i_we_reg     (we_reg),
    .me_bus          (bus),
    .me_o_stall      (stall),
    .me_o_ce         (o_ce),
    .me_o_we_reg     (o_we_reg),
    .me_o_addr_rd    (o_addr_rd),
    .me_o_data_rd    (o_data_rd),
    .me_o_misaligned (o_mis),
    .me_o_dbg_state  (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive_idle();
    ce        = 1'b0;
    flush     = 1'b0;
    opcode    = '0;
    funct3    = '0;
    alu_value = '0;
    data_rs2  = '0;
    addr_rd   = '0;
    data_rd   = '0;
    we_reg    = 1'b0;
    bus.me_i_ack   = 1'b0;
    bus.me_i_rdata = '0;
  endtask

  task automatic drive_op(input logic [10:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] s, input logic [31:0] w, input logic [4:0] rd);
    ce        = 1'b1;
    flush     = 1'b0;
    opcode    = op;
    funct3    = f3;
    alu_value = a;
    data_rs2  = s;
    data_rd   = w;
    addr_rd   = rd;
    we_reg    = 1'b1;
  endtask

  task automatic chk_bus(input vec_t v);
    chk({v.name, ".req"},   {31'h0, bus.me_o_req}, 32'd1);
    chk({v.name, ".addr"},  bus.me_o_addr, v.e_addr);
    chk({v.name, ".we"},    {31'h0, bus.me_o_we}, {31'h0, v.e_we});
    chk({v.name, ".wdata"}, bus.me_o_wdata, v.e_wdata);
    chk({v.name, ".wmask"}, {28'h0, bus.me_o_wmask}, {28'h0, v.e_wmask});
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_op(v.opcode, v.f3, v.addr, v.rs2, v.wb, v.rd);
    #1;
    chk({v.name, ".stall_issue"}, {31'h0, stall}, {31'h0, v.bus});
    @(negedge clk);
    drive_idle();
    if (v.bus) begin
      for (int k = 1; k < v.delay; k++) begin
        chk_bus(v);
        chk({v.name, ".stall_busy"}, {31'h0, stall}, 32'd1);
        @(negedge clk);
      end
      chk_bus(v);
      bus.me_i_ack   = 1'b1;
      bus.me_i_rdata = v.rdata;
      #1;
      chk({v.name, ".stall_ack"}, {31'h0, stall}, 32'd0);
      @(negedge clk);
      bus.me_i_ack = 1'b0;
    end
    chk({v.name, ".req_done"}, {31'h0, bus.me_o_req}, 32'd0);
    chk({v.name, ".ce"},       {31'h0, o_ce}, 32'd1);
    chk({v.name, ".we_reg"},   {31'h0, o_we_reg}, {31'h0, v.e_we_reg});
    chk({v.name, ".mis"},      {31'h0, o_mis}, {31'h0, v.e_mis});
    chk({v.name, ".addr_rd"},  {27'h0, o_addr_rd}, {27'h0, v.rd});
    if (v.chk_data) begin
      exp_q.push_back(v.e_data);
      chk({v.name, ".data_rd"}, o_data_rd, exp_q.pop_front());
    end
    @(negedge clk);
    chk({v.name, ".ce_pulse"},  {31'h0, o_ce}, 32'd0);
    chk({v.name, ".mis_pulse"}, {31'h0, o_mis}, 32'd0);
    chk({v.name, ".state"},     {31'h0, o_state}, 32'd0);
  endtask

  initial begin
    //             name       op      f3      addr          rs2           wb            rd     rdata         dly bus e_addr       we   e_wdata       e_wmask  wreg mis chk e_data
    vecs[0]  = '{"lb_neg",   OP_LD,  3'b000, 32'h0000_1003, 32'h0,        32'h5555_5555, 5'd7, 32'h80AA_BBCC, 3, 1, 32'h0000_1000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80};
    vecs[1]  = '{"lbu",      OP_LD,  3'b100, 32'h0000_1003, 32'h0,        32'h5555_5555, 5'd7, 32'h80AA_BBCC, 3, 1, 32'h0000_1000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 32'h0000_0080};
    vecs[2]  = '{"sh_hi",    OP_ST,  3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 5'd9, 32'h0,        1, 1, 32'h0000_2000, 1'b1, 32'hABCD_ABCD, 4'b1100, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{"lw_mis",   OP_LD,  3'b010, 32'h0000_2001, 32'h0,        32'h5555_5555, 5'd8, 32'h0,        0, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{"add",      OP_ADD, 3'b000, 32'h0000_0099, 32'h0,        32'h0000_0042, 5'd5, 32'h0,        0, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 32'h0000_0042};
    vecs[5]  = '{"lw_rd0",   OP_LD,  3'b010, 32'h0000_3000, 32'h0,        32'h5555_5555, 5'd0, 32'hDEAD_BEEF, 2, 1, 32'h0000_3000, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{"lh_hi",    OP_LD,  3'b001, 32'h0000_4002, 32'h0,        32'h5555_5555, 5'd3, 32'h8001_7FFF, 1, 1, 32'h0000_4000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_8001};
    vecs[7]  = '{"lhu_lo",   OP_LD,  3'b101, 32'h0000_4000, 32'h0,        32'h5555_5555, 5'd4, 32'h8001_F00D, 2, 1, 32'h0000_4000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 32'h0000_F00D};
    vecs[8]  = '{"sb_b1",    OP_ST,  3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h5555_5555, 5'd1, 32'h0,        1, 1, 32'h0000_5000, 1'b1, 32'hA5A5_A5A5, 4'b0010, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{"sw",       OP_ST,  3'b010, 32'h0000_6000, 32'hCAFE_F00D, 32'h5555_5555, 5'd1, 32'h0,        2, 1, 32'h0000_6000, 1'b1, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"lh_mis",   OP_LD,  3'b001, 32'h0000_4001, 32'h0,        32'h5555_5555, 5'd2, 32'h0,        0, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{"lb_b1",    OP_LD,  3'b000, 32'h0000_7001, 32'h0,        32'h5555_5555, 5'd2, 32'h1122_3344, 1, 1, 32'h0000_7000, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 1'b1, 32'h0000_0033};
    vecs[12] = '{"sh_lo",    OP_ST,  3'b001, 32'h0000_2000, 32'hFFFF_0011, 32'h5555_5555, 5'd6, 32'h0,        1, 1, 32'h0000_2000, 1'b1, 32'h0011_0011, 4'b0011, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset held with ack and ce both high
    drive_idle();
    rst = 1'b0;
    drive_op(OP_LD, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 5'd1);
    bus.me_i_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.req",     {31'h0, bus.me_o_req}, 32'd0);
      chk("rst.we",      {31'h0, bus.me_o_we}, 32'd0);
      chk("rst.addr",    bus.me_o_addr, 32'd0);
      chk("rst.wdata",   bus.me_o_wdata, 32'd0);
      chk("rst.wmask",   {28'h0, bus.me_o_wmask}, 32'd0);
      chk("rst.ce",      {31'h0, o_ce}, 32'd0);
      chk("rst.we_reg",  {31'h0, o_we_reg}, 32'd0);
      chk("rst.addr_rd", {27'h0, o_addr_rd}, 32'd0);
      chk("rst.data_rd", o_data_rd, 32'd0);
      chk("rst.mis",     {31'h0, o_mis}, 32'd0);
      chk("rst.stall",   {31'h0, stall}, 32'd0);
      chk("rst.state",   {31'h0, o_state}, 32'd0);
    end
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst.req",   {31'h0, bus.me_o_req}, 32'd0);
    chk("post_rst.state", {31'h0, o_state}, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Passthrough squashed by flush
    @(negedge clk);
    drive_op(OP_ADD, 3'b000, 32'h0, 32'h0, 32'h0000_0042, 5'd5);
    flush = 1'b1;
    #1;
    chk("flush_add.stall", {31'h0, stall}, 32'd0);
    @(negedge clk);
    drive_idle();
    chk("flush_add.ce",     {31'h0, o_ce}, 32'd0);
    chk("flush_add.we_reg", {31'h0, o_we_reg}, 32'd0);

    // Flush and ce asserted while a load is outstanding
    drive_op(OP_LD, 3'b010, 32'h0000_0104, 32'h0, 32'h0, 5'd6);
    @(negedge clk);
    drive_op(OP_ADD, 3'b000, 32'h0, 32'h0, 32'h0000_0077, 5'd9);
    flush = 1'b1;
    chk("busy_flush.req",  {31'h0, bus.me_o_req}, 32'd1);
    chk("busy_flush.addr", bus.me_o_addr, 32'h0000_0104);
    @(negedge clk);
    chk("busy_flush.req2",  {31'h0, bus.me_o_req}, 32'd1);
    chk("busy_flush.stall", {31'h0, stall}, 32'd1);
    bus.me_i_ack   = 1'b1;
    bus.me_i_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    drive_idle();
    chk("busy_flush.ce",      {31'h0, o_ce}, 32'd1);
    chk("busy_flush.we_reg",  {31'h0, o_we_reg}, 32'd1);
    chk("busy_flush.addr_rd", {27'h0, o_addr_rd}, 32'd6);
    exp_q.push_back(32'h0BAD_F00D);
    chk("busy_flush.data_rd", o_data_rd, exp_q.pop_front());
    @(negedge clk);

    // Reset while a load is outstanding, then a late ack
    drive_op(OP_LD, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    drive_idle();
    chk("busy_rst.req_before", {31'h0, bus.me_o_req}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("busy_rst.req",   {31'h0, bus.me_o_req}, 32'd0);
    chk("busy_rst.state", {31'h0, o_state}, 32'd0);
    rst = 1'b1;
    bus.me_i_ack   = 1'b1;
    bus.me_i_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.me_i_ack = 1'b0;
    chk("late_ack.ce",     {31'h0, o_ce}, 32'd0);
    chk("late_ack.we_reg", {31'h0, o_we_reg}, 32'd0);
    chk("late_ack.req",    {31'h0, bus.me_o_req}, 32'd0);
    @(negedge clk);
    chk("late_ack.ce2",    {31'h0, o_ce}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
